key_event: RTL and testbench

KEY_EVENT -- requirements
Module: key_event

---
 rtl/key_pkg.sv | 29 ++
 rtl/key_timer.sv | 29 ++
 rtl/key_event.sv | 148 ++++++++++++++
 tb/tb_key_event.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared constants and state encoding for the key event decoder.
package key_pkg;

    localparam int unsigned CNT_W             = 26;
    localparam int unsigned ST_W              = 5;
    localparam int unsigned LONG_CYCLES_DEF   = 50_000_000;
    localparam int unsigned DBL_CYCLES_DEF    = 15_000_000;
    localparam int unsigned REPEAT_CYCLES_DEF = 10_000_000;

    localparam logic [ST_W-1:0] ONEHOT_IDLE      = 5'b00001;
    localparam logic [ST_W-1:0] ONEHOT_PRESS1    = 5'b00010;
    localparam logic [ST_W-1:0] ONEHOT_LONG_HOLD = 5'b00100;
    localparam logic [ST_W-1:0] ONEHOT_WAIT2     = 5'b01000;
    localparam logic [ST_W-1:0] ONEHOT_PRESS2    = 5'b10000;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE      = ONEHOT_IDLE,
        ST_PRESS1    = ONEHOT_PRESS1,
        ST_LONG_HOLD = ONEHOT_LONG_HOLD,
        ST_WAIT2     = ONEHOT_WAIT2,
        ST_PRESS2    = ONEHOT_PRESS2
    } state_t;

    // Terminal count for a period of the given length.
    function automatic logic [CNT_W-1:0] cyc_limit(input int unsigned cycles);
        return CNT_W'(cycles - 32'd1);
    endfunction

endpackage

// File: rtl/key_timer.sv
// Free-running cycle counter with synchronous clear and equality hit against a runtime limit.
module key_timer
    import key_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [CNT_W-1:0] i_limit,
    output logic [CNT_W-1:0] o_count,
    output logic             o_hit_c
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;
    assign o_hit_c = i_en && (r_count == i_limit);

endmodule

// File: rtl/key_event.sv
// Classifies debounced key transitions into short, double, long and auto-repeat pulses.
module key_event
    import key_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
    parameter int unsigned DBL_CYCLES    = DBL_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic key_flag,
    input  logic key_state,
    output logic short_press,
    output logic double_click,
    output logic long_press,
    output logic repeat_tick,
    output logic busy
);

    localparam logic [CNT_W-1:0] LONG_LIM   = cyc_limit(LONG_CYCLES);
    localparam logic [CNT_W-1:0] DBL_LIM    = cyc_limit(DBL_CYCLES);
    localparam logic [CNT_W-1:0] REPEAT_LIM = cyc_limit(REPEAT_CYCLES);
    localparam int unsigned CNT_MAX =
        ((LONG_CYCLES > DBL_CYCLES) ? LONG_CYCLES : DBL_CYCLES) - 32'd1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_short, r_dbl, r_long, r_rep, r_busy;
    logic             w_short_nxt, w_dbl_nxt, w_long_nxt, w_rep_nxt;
    logic             w_press, w_release;
    logic             w_en, w_clr, w_hit;
    logic [CNT_W-1:0] w_limit;
    logic [CNT_W-1:0] w_count;

    assign w_press   = key_flag &  key_state;
    assign w_release = key_flag & ~key_state;
    assign w_en      = (r_state != ST_IDLE);

    // Threshold depends only on the current state, keeping the hit path acyclic.
    always_comb begin
        w_limit = LONG_LIM;
        case (r_state)
            ST_LONG_HOLD: w_limit = REPEAT_LIM;
            ST_WAIT2:     w_limit = DBL_LIM;
            default:      w_limit = LONG_LIM;
        endcase
    end

    key_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_en),
        .i_clr   (w_clr),
        .i_limit (w_limit),
        .o_count (w_count),
        .o_hit_c (w_hit)
    );

    // Key events are tested before the timer hit so they win a same-cycle tie.
    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_short_nxt = 1'b0;
        w_dbl_nxt   = 1'b0;
        w_long_nxt  = 1'b0;
        w_rep_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_press) begin
                    w_state_nxt = ST_PRESS1;
                    w_clr       = 1'b1;
                end
            end
            ST_PRESS1: begin
                if (w_release) begin
                    w_state_nxt = ST_WAIT2;
                    w_clr       = 1'b1;
                end else if (w_hit) begin
                    w_state_nxt = ST_LONG_HOLD;
                    w_clr       = 1'b1;
                    w_long_nxt  = 1'b1;
                end
            end
            ST_LONG_HOLD: begin
                if (w_release) begin
                    w_state_nxt = ST_IDLE;
                    w_clr       = 1'b1;
                end else if (w_hit) begin
                    w_clr       = 1'b1;
                    w_rep_nxt   = 1'b1;
                end
            end
            ST_WAIT2: begin
                if (w_press) begin
                    w_state_nxt = ST_PRESS2;
                    w_clr       = 1'b1;
                end else if (w_hit) begin
                    w_state_nxt = ST_IDLE;
                    w_clr       = 1'b1;
                    w_short_nxt = 1'b1;
                end
            end
            ST_PRESS2: begin
                if (w_release) begin
                    w_state_nxt = ST_IDLE;
                    w_clr       = 1'b1;
                    w_dbl_nxt   = 1'b1;
                end else if (w_hit) begin
                    w_state_nxt = ST_LONG_HOLD;
                    w_clr       = 1'b1;
                    w_long_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_clr       = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_short <= 1'b0;
            r_dbl   <= 1'b0;
            r_long  <= 1'b0;
            r_rep   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_short <= w_short_nxt;
            r_dbl   <= w_dbl_nxt;
            r_long  <= w_long_nxt;
            r_rep   <= w_rep_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    assign short_press  = r_short;
    assign double_click = r_dbl;
    assign long_press   = r_long;
    assign repeat_tick  = r_rep;
    assign busy         = r_busy;

    a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
        w_count <= CNT_W'(CNT_MAX));

endmodule

// File: tb/tb_key_event.sv
// Directed, table-driven check of key_event with short test timings.
module tb_key_event;

    localparam logic [4:0] B  = 5'b00001;
    localparam logic [4:0] RP = 5'b00010;
    localparam logic [4:0] LG = 5'b00100;
    localparam logic [4:0] DB = 5'b01000;
    localparam logic [4:0] SH = 5'b10000;

    typedef struct {
        int         rep;
        logic       flag;
        logic       st;
        logic [4:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_flag = 1'b0;
    logic key_state = 1'b0;
    logic short_press, double_click, long_press, repeat_tick, busy;
    logic [4:0] outs;

    int n_vec = 0;
    int n_bad = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    key_event #(
        .LONG_CYCLES   (20),
        .DBL_CYCLES    (10),
        .REPEAT_CYCLES (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_flag     (key_flag),
        .key_state    (key_state),
        .short_press  (short_press),
        .double_click (double_click),
        .long_press   (long_press),
        .repeat_tick  (repeat_tick),
        .busy         (busy)
    );

    assign outs = {short_press, double_click, long_press, repeat_tick, busy};

    task automatic add(input int n, input logic f, input logic s, input logic [4:0] e);
        vec_t v;
        v.rep = n; v.flag = f; v.st = s; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic check(input string tag, input logic [4:0] req);
        n_vec++;
        if (outs !== req) begin
            n_bad++;
            $display("FAIL %s: {short,dbl,long,rep,busy}=%b required=%b", tag, outs, req);
        end
    endtask

    // Drive one cycle of inputs, then sample after the edge that consumes them.
    task automatic step(input logic f, input logic s);
        @(negedge clk);
        key_flag  = f;
        key_state = s;
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n, input logic s, input logic [4:0] req, input string tag);
        for (int k = 0; k < n; k++) begin
            step(1'b0, s);
            check(tag, req);
        end
    endtask

    initial begin
        // short click
        add(1,1,1,B); add(4,0,1,B); add(1,1,0,B); add(9,0,0,B); add(1,0,0,SH); add(3,0,0,0);
        // double click
        add(1,1,1,B); add(4,0,1,B); add(1,1,0,B); add(3,0,0,B); add(1,1,1,B);
        add(2,0,1,B); add(1,1,0,DB); add(12,0,0,0);
        // long press with two repeats
        add(1,1,1,B); add(19,0,1,B); add(1,0,1,LG|B); add(4,0,1,B); add(1,0,1,RP|B);
        add(4,0,1,B); add(1,0,1,RP|B); add(1,0,1,B); add(1,1,0,0); add(5,0,0,0);
        // release on the long threshold, press on the double timeout
        add(1,1,1,B); add(19,0,1,B); add(1,1,0,B); add(9,0,0,B); add(1,1,1,B);
        add(1,1,0,DB); add(3,0,0,0);
        // release in idle ignored, duplicate press ignored
        add(1,1,0,0); add(1,1,1,B); add(5,0,1,B); add(1,1,1,B); add(13,0,1,B);
        add(1,0,1,LG|B); add(1,1,0,0);
        // second press held into long press
        add(1,1,1,B); add(1,1,0,B); add(1,0,0,B); add(1,1,1,B); add(19,0,1,B);
        add(1,0,1,LG|B); add(1,1,0,0); add(3,0,0,0);
        // duplicate release in WAIT2 keeps the timeout
        add(1,1,1,B); add(1,1,0,B); add(4,0,0,B); add(1,1,0,B); add(4,0,0,B); add(1,0,0,SH);
        add(2,0,0,0);

        #12;
        check("reset_state", 5'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            for (int r = 0; r < tbl[i].rep; r++) begin
                step(tbl[i].flag, tbl[i].st);
                check($sformatf("row%0d.%0d", i, r), tbl[i].exp);
            end
        end

        // reset while waiting for a second press
        step(1'b1, 1'b1); check("w2_press", B);
        steps(4, 1'b1, B, "w2_hold");
        step(1'b1, 1'b0); check("w2_rel", B);
        steps(3, 1'b0, B, "w2_wait");
        #2 rst = 1'b1;
        #1 check("w2_async_rst", 5'b0);
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        steps(20, 1'b0, 5'b0, "w2_post_rst");

        // reset clears a pulse already on the output
        step(1'b1, 1'b1); check("pk_press", B);
        steps(4, 1'b1, B, "pk_hold");
        step(1'b1, 1'b0); check("pk_rel", B);
        steps(9, 1'b0, B, "pk_wait");
        step(1'b0, 1'b0); check("pk_short", SH);
        #2 rst = 1'b1;
        #1 check("pk_async_rst", 5'b0);
        @(negedge clk) rst = 1'b0;

        // key held across reset produces nothing until a fresh press
        step(1'b1, 1'b1); check("hd_press", B);
        steps(3, 1'b1, B, "hd_hold");
        #2 rst = 1'b1;
        #1 check("hd_async_rst", 5'b0);
        @(negedge clk) rst = 1'b0;
        steps(25, 1'b1, 5'b0, "hd_held");
        step(1'b1, 1'b0); check("hd_rel_idle", 5'b0);
        step(1'b1, 1'b1); check("hd_repress", B);
        step(1'b1, 1'b0); check("hd_rel", B);
        steps(9, 1'b0, B, "hd_wait");
        step(1'b0, 1'b0); check("hd_short", SH);
        step(1'b0, 1'b0); check("hd_idle", 5'b0);

        key_flag = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
